// File: rtl/mem_arbiter_up_if.sv
// Pipeline-side and memory-side signals of the shared memory port arbiter.
// The arbiter connects through the slave modport; the pipeline/memory
// environment drives through the master modport.
interface mem_arbiter_up_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            i_valid;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_wstrb;
    logic [DW-1:0]   d_rdata;
    logic            d_valid;

    logic            flush;

    logic            m_req;
    logic            m_we;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_ack;
    logic [DW-1:0]   m_rdata;

    logic            stall_f;
    logic            stall_m;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, flush, m_ack, m_rdata,
        output i_rdata, i_valid, d_rdata, d_valid, m_req, m_we, m_addr, m_wdata, m_wstrb,
               stall_f, stall_m
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, flush, m_ack, m_rdata,
        input  i_rdata, i_valid, d_rdata, d_valid, m_req, m_we, m_addr, m_wdata, m_wstrb,
               stall_f, stall_m
    );
endinterface

// File: rtl/mem_arbiter_up.sv
// Shared memory port arbiter between instruction fetch and data memory stages.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no transaction outstanding; arbitrate this cycle
//   I_BUSY | fetch transaction on the memory port, waiting for m_ack
//   D_BUSY | load/store transaction on the memory port, waiting for m_ack
//   I_DROP | fetch cancelled by flush; wait for m_ack, return nothing
module mem_arbiter_up #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 4
) (
    input logic             clk,
    input logic             rst_n,
    mem_arbiter_up_if.slave bus
);
    localparam int              SW         = $clog2(MAX_D_BURST + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        I_DROP = 2'd3
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_d_streak;
    logic            r_m_req;
    logic            r_m_we;
    logic [AW-1:0]   r_m_addr;
    logic [DW-1:0]   r_m_wdata;
    logic [DW/8-1:0] r_m_wstrb;

    logic            w_idle;
    logic            w_grant_i;
    logic            w_grant_d;

    // Arbitration: data wins unless the waiting fetch has used up its patience.
    always_comb begin
        w_idle    = (r_state == IDLE);
        w_grant_i = w_idle & bus.i_req & ~bus.flush & (~bus.d_req | (r_d_streak == STREAK_MAX));
        w_grant_d = w_idle & bus.d_req & ~w_grant_i;
    end

    // Transaction FSM with the registered memory-side request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_wstrb <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_state   <= I_BUSY;
                        r_m_req   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= bus.i_addr;
                        r_m_wdata <= '0;
                        r_m_wstrb <= '0;
                    end else if (w_grant_d) begin
                        r_state   <= D_BUSY;
                        r_m_req   <= 1'b1;
                        r_m_we    <= bus.d_we;
                        r_m_addr  <= bus.d_addr;
                        r_m_wdata <= bus.d_wdata;
                        r_m_wstrb <= bus.d_wstrb;
                    end
                end
                I_BUSY: begin
                    if (bus.m_ack) begin
                        r_state <= IDLE;
                        r_m_req <= 1'b0;
                    end else if (bus.flush) begin
                        r_state <= I_DROP;
                    end
                end
                D_BUSY, I_DROP: begin
                    if (bus.m_ack) begin
                        r_state <= IDLE;
                        r_m_req <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_m_req <= 1'b0;
                end
            endcase
        end
    end

    // Data grants taken while a fetch is waiting; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_streak <= '0;
        end else if (!bus.i_req || w_grant_i) begin
            r_d_streak <= '0;
        end else if (w_grant_d && (r_d_streak != STREAK_MAX)) begin
            r_d_streak <= r_d_streak + SW'(1);
        end
    end

    assign bus.m_req   = r_m_req;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_wstrb = r_m_wstrb;

    // A flush arriving with the ack still kills the fetch result.
    assign bus.i_valid = (r_state == I_BUSY) & bus.m_ack & ~bus.flush;
    assign bus.d_valid = (r_state == D_BUSY) & bus.m_ack;
    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;

    assign bus.stall_f = bus.i_req & ~bus.i_valid;
    assign bus.stall_m = bus.d_req & ~bus.d_valid;
endmodule

// File: tb/tb_mem_arbiter_up.sv
// Self-checking bench for mem_arbiter_up: directed vectors, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter_up;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_arbiter_up_if #(.AW(AW), .DW(DW)) bus();

    mem_arbiter_up #(.AW(AW), .DW(DW), .MAX_D_BURST(MAXB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          use_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        int            delay;
        logic [DW-1:0] rdata;
        logic          exp_we;
        logic [3:0]    exp_wstrb;
    } vec_t;

    vec_t vecs [6];

    // reference model state for the random phase
    bit            mb_busy, mb_own_d, mb_drop, gi, gd, ev_i, ev_d, i_pend, d_pend;
    logic [AW-1:0] mb_addr;
    logic          mb_we;
    logic [DW-1:0] mb_wdata;
    logic [3:0]    mb_wstrb;
    int            mb_streak, mb_wait;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        if (v.use_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
            bus.d_wdata = v.wdata; bus.d_wstrb = v.wstrb;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = v.addr;
            bus.d_we = v.we; bus.d_wstrb = v.wstrb; bus.d_wdata = v.wdata;
        end
        tick;
        chk($sformatf("vec%0d_m_req", idx), bus.m_req, 1'b1);
        chk($sformatf("vec%0d_m_addr", idx), bus.m_addr, v.addr);
        chk($sformatf("vec%0d_m_we", idx), bus.m_we, v.exp_we);
        chk($sformatf("vec%0d_m_wstrb", idx), bus.m_wstrb, v.exp_wstrb);
        if (v.use_d) chk($sformatf("vec%0d_m_wdata", idx), bus.m_wdata, v.wdata);
        // requester fields move while busy; the latched copy must not
        bus.i_addr = ~v.addr; bus.d_addr = ~v.addr; bus.d_wdata = ~v.wdata;
        for (int k = 0; k < v.delay; k++) begin
            #1;
            chk($sformatf("vec%0d_wait_valid", idx), {bus.i_valid, bus.d_valid}, 2'b00);
            tick;
            chk($sformatf("vec%0d_hold_req", idx), bus.m_req, 1'b1);
            chk($sformatf("vec%0d_hold_addr", idx), bus.m_addr, v.addr);
        end
        bus.m_ack = 1'b1; bus.m_rdata = v.rdata;
        #1;
        chk($sformatf("vec%0d_valid", idx), {bus.i_valid, bus.d_valid}, v.use_d ? 2'b01 : 2'b10);
        chk($sformatf("vec%0d_rdata", idx), v.use_d ? bus.d_rdata : bus.i_rdata, v.rdata);
        tick;
        bus.m_ack = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk($sformatf("vec%0d_release", idx), bus.m_req, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run reached time %0t, limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 0, 32'h1111_2222, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'hF, 2, 32'h0,         1'b1, 4'hF};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0104, 32'h0,         4'hF, 1, 32'h0000_0013, 1'b0, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_3000, 32'h0000_55AA, 4'h5, 3, 32'h0,         1'b1, 4'h5};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,         4'h0, 0, 32'h89AB_CDEF, 1'b0, 4'h0};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1, 32'h5A5A_A5A5, 1'b0, 4'h0};

        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
        bus.d_wdata = 0; bus.d_wstrb = 0; bus.flush = 0; bus.m_ack = 1; bus.m_rdata = 0;

        // reset state (ack held high must not produce valids)
        tick; tick;
        chk("rst_m_req", bus.m_req, 1'b0);
        chk("rst_m_we", bus.m_we, 1'b0);
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_m_wdata", bus.m_wdata, 32'h0);
        chk("rst_m_wstrb", bus.m_wstrb, 4'h0);
        chk("rst_valids", {bus.i_valid, bus.d_valid}, 2'b00);
        chk("rst_stalls", {bus.stall_f, bus.stall_m}, 2'b00);
        bus.m_ack = 0;
        rst_n = 1'b1;
        tick;

        // single fetch, ack on first m_req cycle
        bus.i_req = 1; bus.i_addr = 32'h100;
        #1 chk("t1_stall_f_wait", bus.stall_f, 1'b1);
        tick;
        chk("t1_m_req", bus.m_req, 1'b1);
        chk("t1_m_addr", bus.m_addr, 32'h100);
        bus.m_ack = 1; bus.m_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_i_valid", bus.i_valid, 1'b1);
        chk("t1_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        chk("t1_stall_f", bus.stall_f, 1'b0);
        tick;
        bus.m_ack = 0; bus.i_req = 0;
        #1;
        chk("t1_after_m_req", bus.m_req, 1'b0);
        chk("t1_after_i_valid", bus.i_valid, 1'b0);
        chk("t1_after_stall_f", bus.stall_f, 1'b0);
        tick;

        // directed transaction table
        for (int v = 0; v < 6; v++) run_vec(vecs[v], v);
        tick;

        // simultaneous requests: store wins, fetch follows after one idle cycle
        bus.i_req = 1; bus.i_addr = 32'h40;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'h3;
        tick;
        chk("t2_d_addr", bus.m_addr, 32'h2000);
        chk("t2_d_we", bus.m_we, 1'b1);
        chk("t2_d_wstrb", bus.m_wstrb, 4'h3);
        bus.m_ack = 1; bus.m_rdata = 32'h0;
        #1;
        chk("t2_valids_d", {bus.i_valid, bus.d_valid}, 2'b01);
        chk("t2_stalls", {bus.stall_f, bus.stall_m}, 2'b10);
        tick;
        bus.m_ack = 0; bus.d_req = 0; bus.d_we = 0;
        chk("t2_gap_m_req", bus.m_req, 1'b0);
        tick;
        chk("t2_i_addr", bus.m_addr, 32'h40);
        chk("t2_i_we", bus.m_we, 1'b0);
        chk("t2_i_wstrb", bus.m_wstrb, 4'h0);
        bus.m_ack = 1; bus.m_rdata = 32'h0000_ABCD;
        #1;
        chk("t2_valids_i", {bus.i_valid, bus.d_valid}, 2'b10);
        chk("t2_i_rdata", bus.i_rdata, 32'h0000_ABCD);
        tick;
        bus.m_ack = 0; bus.i_req = 0;
        tick;

        // anti-starvation: four data grants, then the fetch, repeating
        bus.i_req = 1; bus.i_addr = 32'h400;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h5000; bus.d_wstrb = 0;
        for (int g = 0; g < 10; g++) begin
            tick;
            chk($sformatf("t3_grant%0d_addr", g), bus.m_addr, (g % 5 == 4) ? 32'h400 : 32'h5000);
            bus.m_ack = 1;
            #1;
            chk($sformatf("t3_grant%0d_valid", g), {bus.i_valid, bus.d_valid}, (g % 5 == 4) ? 2'b10 : 2'b01);
            tick;
            bus.m_ack = 0;
        end
        bus.i_req = 0; bus.d_req = 0;
        tick;

        // flush the cycle after a fetch grant; ack three cycles later
        bus.i_req = 1; bus.i_addr = 32'h300;
        tick;
        chk("t4_grant", bus.m_req, 1'b1);
        bus.flush = 1; bus.i_req = 0;
        #1 chk("t4_flush_iv", bus.i_valid, 1'b0);
        tick;
        bus.flush = 0;
        chk("t4_drop_req1", bus.m_req, 1'b1);
        chk("t4_drop_addr", bus.m_addr, 32'h300);
        tick;
        chk("t4_drop_req2", bus.m_req, 1'b1);
        bus.m_ack = 1; bus.m_rdata = 32'h7777;
        #1 chk("t4_drop_iv", {bus.i_valid, bus.d_valid}, 2'b00);
        tick;
        bus.m_ack = 0;
        chk("t4_after_req", bus.m_req, 1'b0);
        tick;
        chk("t4_idle_req", bus.m_req, 1'b0);

        // flush coincident with ack in fetch
        bus.i_req = 1; bus.i_addr = 32'h500;
        tick;
        bus.m_ack = 1; bus.flush = 1;
        #1;
        chk("t5a_iv", bus.i_valid, 1'b0);
        chk("t5a_stall_f", bus.stall_f, 1'b1);
        tick;
        bus.m_ack = 0; bus.flush = 0; bus.i_req = 0;
        chk("t5a_after_req", bus.m_req, 1'b0);
        tick;

        // flush during data transaction does not cancel it
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h6000;
        tick;
        bus.flush = 1;
        tick;
        chk("t5b_req_kept", bus.m_req, 1'b1);
        bus.m_ack = 1;
        #1 chk("t5b_dv", bus.d_valid, 1'b1);
        tick;
        bus.m_ack = 0; bus.flush = 0; bus.d_req = 0;
        tick;

        // asynchronous reset in the middle of a store
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h7000; bus.d_wdata = 32'hFFFF_0000; bus.d_wstrb = 4'hC;
        tick;
        chk("t6_pre_req", bus.m_req, 1'b1);
        rst_n = 0; bus.m_ack = 1;
        #1;
        chk("t6_m_req", bus.m_req, 1'b0);
        chk("t6_m_addr", bus.m_addr, 32'h0);
        chk("t6_m_we", bus.m_we, 1'b0);
        chk("t6_m_wdata", bus.m_wdata, 32'h0);
        chk("t6_m_wstrb", bus.m_wstrb, 4'h0);
        chk("t6_d_valid", bus.d_valid, 1'b0);
        chk("t6_stall_m", bus.stall_m, 1'b1);
        tick;
        rst_n = 1; bus.m_ack = 0; bus.d_req = 0;
        tick;
        chk("t6_idle", bus.m_req, 1'b0);
        bus.d_req = 1;
        tick;
        chk("t6_regrant", bus.m_addr, 32'h7000);
        bus.m_ack = 1;
        #1 chk("t6_regrant_dv", bus.d_valid, 1'b1);
        tick;
        bus.m_ack = 0; bus.d_req = 0; bus.d_we = 0;

        // randomized traffic against the reference model
        rst_n = 0;
        tick;
        rst_n = 1;
        tick;
        mb_busy = 0; mb_own_d = 0; mb_drop = 0; mb_streak = 0; mb_wait = 0;
        mb_addr = 0; mb_we = 0; mb_wdata = 0; mb_wstrb = 0;
        i_pend = 0; d_pend = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_m_req", bus.m_req, mb_busy);
            if (mb_busy) begin
                chk("rnd_m_addr", bus.m_addr, mb_addr);
                chk("rnd_m_we", bus.m_we, mb_we);
                chk("rnd_m_wstrb", bus.m_wstrb, mb_wstrb);
                if (mb_own_d) chk("rnd_m_wdata", bus.m_wdata, mb_wdata);
            end
            if (!i_pend && $urandom_range(0, 3) == 0) begin
                i_pend = 1; bus.i_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom;
                bus.d_wdata = $urandom; bus.d_wstrb = 4'($urandom_range(0, 15));
            end
            bus.flush = ($urandom_range(0, 7) == 0);
            if (bus.flush && i_pend) begin
                bus.i_addr = $urandom;
                if ($urandom_range(0, 1) == 1) i_pend = 0;
            end
            bus.i_req = i_pend;
            bus.d_req = d_pend;
            if (mb_busy) begin
                bus.m_ack = (mb_wait == 0);
                if (mb_wait > 0) mb_wait--;
            end else begin
                bus.m_ack = ($urandom_range(0, 7) == 0);
            end
            bus.m_rdata = $urandom;
            #1;
            ev_i = mb_busy && !mb_own_d && !mb_drop && bus.m_ack && !bus.flush;
            ev_d = mb_busy && mb_own_d && bus.m_ack;
            chk("rnd_i_valid", bus.i_valid, ev_i);
            chk("rnd_d_valid", bus.d_valid, ev_d);
            chk("rnd_stall_f", bus.stall_f, i_pend && !ev_i);
            chk("rnd_stall_m", bus.stall_m, d_pend && !ev_d);
            if (ev_i) chk("rnd_i_rdata", bus.i_rdata, bus.m_rdata);
            if (ev_d) chk("rnd_d_rdata", bus.d_rdata, bus.m_rdata);
            gi = 0; gd = 0;
            if (mb_busy) begin
                if (bus.m_ack) mb_busy = 0;
                else if (!mb_own_d && bus.flush) mb_drop = 1;
            end else begin
                if (d_pend && i_pend && !bus.flush && mb_streak == MAXB) gi = 1;
                else if (d_pend) gd = 1;
                else if (i_pend && !bus.flush) gi = 1;
                if (gi || gd) begin
                    mb_busy  = 1;
                    mb_own_d = gd;
                    mb_drop  = 0;
                    mb_wait  = $urandom_range(0, 3);
                    mb_addr  = gd ? bus.d_addr : bus.i_addr;
                    mb_we    = gd ? bus.d_we : 1'b0;
                    mb_wstrb = gd ? bus.d_wstrb : 4'h0;
                    mb_wdata = bus.d_wdata;
                end
            end
            if (!i_pend || gi) mb_streak = 0;
            else if (gd && mb_streak < MAXB) mb_streak++;
            if (ev_i) i_pend = 0;
            if (ev_d) d_pend = 0;
            tick;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
